axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

Parametrised AXI4-Lite memory slave that terminates the PicoRV32 `mem_axi_*` bus in the UVM bench. It replaces the signal-only bundle with a behavioural endpoint. It adds configurable data width and depth, independent AW/W capture, response codes, and LFSR-driven ready back-pressure (`AXI_TEST` mode). It also provides console and pass-flag side effects, so the bench can detect `tests_passed` without a testbench-side memory.

## Interface
- `DATA_W`, 32: bus data width; legal values are 32 or 64. `STRB_W = DATA_W/8`.
- `ADDR_W`, 32: address width.
- `MEM_WORDS`, 1024: memory depth in `DATA_W` words; must be a power of two.
- `AXI_TEST`, 0: 1 = pseudo-random ready throttling; 0 = readies always offered in idle.
- `LFSR_SEED`, 16'hACE1: throttle LFSR reset value; must be non-zero.
- `CONSOLE_ADDR`, 32'h1000_0000: console write address.
- `PASS_ADDR`, 32'h2000_0000: pass-flag write address.
- `PASS_VALUE`, 123456789: data value that sets `tests_passed`.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `mem_axi_awvalid`/`mem_axi_awready` in/out 1; `mem_axi_awaddr` in `ADDR_W`; `mem_axi_awprot` in 3 (ignored).
- `mem_axi_wvalid`/`mem_axi_wready` in/out 1; `mem_axi_wdata` in `DATA_W`; `mem_axi_wstrb` in `STRB_W`.
- `mem_axi_bvalid`/`mem_axi_bready` out/in 1; `mem_axi_bresp` out 2.
- `mem_axi_arvalid`/`mem_axi_arready` in/out 1; `mem_axi_araddr` in `ADDR_W`; `mem_axi_arprot` in 3 (ignored).
- `mem_axi_rvalid`/`mem_axi_rready` out/in 1; `mem_axi_rdata` out `DATA_W`; `mem_axi_rresp` out 2.
- `console_valid` out 1: one-cycle pulse on a console write.
- `console_data` out 8: `wdata[7:0]` of the console write.
- `tests_passed` out 1: sticky pass flag.

## Operation
**Write FSM** states: `W_IDLE`, `W_RESP`.
- In `W_IDLE`, AW and W are captured independently.
  - Once a channel is captured, its ready drops until the response completes.
- When both are held, the write commits and the FSM enters `W_RESP`. The commit and the transition happen in the same cycle as the second capture.
- In `W_RESP`, `bvalid` is held with a stable `bresp` until `bready`, then the FSM returns to `W_IDLE`.

**Read FSM** states: `R_IDLE`, `R_DATA`.
- The AR handshake registers `rdata` and `rresp`, and the FSM enters `R_DATA`.
- `rvalid` and `rdata` are held stable until `rready`.

**Address decode**
- Word index = `addr[$clog2(MEM_WORDS)+$clog2(STRB_W)-1 : $clog2(STRB_W)]`. Low byte-offset bits are ignored.
- An address at or above `MEM_WORDS*STRB_W` that is not a special address returns SLVERR (2'b10):
  - writes are dropped;
  - reads return `rdata = 0`.
- All other accesses return OKAY (2'b00).
- Memory writes apply per-byte under `wstrb`. `wstrb = 0` is OKAY with no change.

**Special addresses (write only)**
- `CONSOLE_ADDR`: pulse `console_valid` for one cycle, coincident with the commit. Memory is untouched.
- `PASS_ADDR`: set `tests_passed` only if `wstrb` is all ones and `wdata[31:0] == PASS_VALUE`. The flag stays set until reset.
- A read of either special address returns 0 with OKAY.

**Back-pressure**
- With `AXI_TEST = 1`, a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. Each ready is additionally gated by its own LFSR bit: bit0 `awready`, bit1 `wready`, bit2 `arready`.
- With `AXI_TEST = 0`, the gating is off.

**Read/write collision**
- An AR handshake in the same cycle as a write commit to the same word returns the pre-write data.

**Reset** (while `reset = 0`):
- both FSMs go to idle and capture flags clear;
- all valids and readies = 0, `bresp`/`rresp` = 0, `rdata` = 0;
- `console_valid` = 0, `tests_passed` = 0;
- the LFSR loads `LFSR_SEED`;
- memory contents are not reset.

A reset mid-transaction abandons it; no response is issued afterwards.

## Timing
- Readies are registered outputs.
  - With `AXI_TEST = 0`, `awready`/`wready`/`arready` are 1 in the first cycle after reset deasserts.
  - `awready` and `wready` remain 1 while their channel is not yet captured.
- Write latency: completing handshake in cycle N → `bvalid = 1` in N+1.
- Read latency: AR handshake in cycle N → `rvalid = 1` with data in N+1.
- Back-to-back throughput: B or R handshake in cycle M → that channel's ready returns in M+1. Peak rate is one transaction per 2 cycles per direction.
- Reads and writes proceed fully concurrently.

## Structure
- `axi_mem_pkg` holds:
  - `resp_e` (`OKAY = 2'b00`, `SLVERR = 2'b10`);
  - the `wstate_e` and `rstate_e` enums;
  - the LFSR tap mask constant.
- One sub-module, `axi_lfsr_throttle` (parameters `SEED` and `EN`), outputs a 3-bit ready-gate vector. When `EN = 0` the vector is tied to all ones.
- Memory is an unpacked array of `MEM_WORDS` x `DATA_W`, inferred in the top module.

## Test plan
- Basic write/read: AW and W together to 0x10, data 0xDEADBEEF, strb 0xF → `bvalid` next cycle with OKAY. A subsequent read of 0x10 returns 0xDEADBEEF with OKAY, 1-cycle latency.
- Split channels and byte strobe: W (0x11223344, strb 0x2) two cycles before AW to 0x10 → `bvalid` only after AW. A read of 0x10 returns 0xDEAD33EF.
- Pass flag: write 123456789 to 0x2000_0000 → `tests_passed = 1` and stays set. A second write with strb 0x7 causes no change; reset then clears the flag.
- Console and SLVERR: write 0x41 to 0x1000_0000 → `console_valid` is a single pulse with `console_data = 0x41`. Write and read at 0x0001_0000 (`MEM_WORDS = 1024`) → SLVERR, and the read returns 0.
- Stress: `AXI_TEST = 1`, 1000 random reads and writes with `bready`/`rready` held low for 0–5 cycles → every response matches a scoreboard, and `bvalid`/`rvalid`/`rdata` stay stable while stalled.
- Reset mid-transaction: reset during `W_RESP` with `bready = 0` → `bvalid = 0` after the reset edge and `awready = 1` in the first cycle after release.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4-Lite memory slave.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  localparam int unsigned LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/axi_lfsr_throttle.sv
// Free-running LFSR producing per-channel ready gates; all ones when disabled.
module axi_lfsr_throttle
  import axi_mem_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter bit                EN   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [2:0] gate_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign gate_o = EN ? lfsr_q[2:0] : 3'b111;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4-Lite memory endpoint with console/pass-flag side effects and optional
// pseudo-random ready throttling.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter bit          AXI_TEST     = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                mem_axi_awvalid,
  output logic                mem_axi_awready,
  input  logic [ADDR_W-1:0]   mem_axi_awaddr,
  input  logic [2:0]          mem_axi_awprot,

  input  logic                mem_axi_wvalid,
  output logic                mem_axi_wready,
  input  logic [DATA_W-1:0]   mem_axi_wdata,
  input  logic [DATA_W/8-1:0] mem_axi_wstrb,

  output logic                mem_axi_bvalid,
  input  logic                mem_axi_bready,
  output logic [1:0]          mem_axi_bresp,

  input  logic                mem_axi_arvalid,
  output logic                mem_axi_arready,
  input  logic [ADDR_W-1:0]   mem_axi_araddr,
  input  logic [2:0]          mem_axi_arprot,

  output logic                mem_axi_rvalid,
  input  logic                mem_axi_rready,
  output logic [DATA_W-1:0]   mem_axi_rdata,
  output logic [1:0]          mem_axi_rresp,

  output logic                console_valid,
  output logic [7:0]          console_data,
  output logic                tests_passed
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned SPAN_W = IDX_W + OFF_W;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic [2:0] ready_gate;

  axi_lfsr_throttle #(
    .SEED (LFSR_SEED),
    .EN   (AXI_TEST)
  ) u_throttle (
    .clk_i  (clk),
    .rst_ni (reset),
    .gate_o (ready_gate)
  );

  // ---------------- write channel ----------------
  wstate_e           wstate_q, wstate_d;
  logic              aw_cap_q, aw_cap_d;
  logic              w_cap_q, w_cap_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  resp_e             bresp_q, bresp_d;
  logic              console_valid_q, console_valid_d;
  logic [7:0]        console_data_q, console_data_d;
  logic              passed_q, passed_d;

  logic              aw_hs_c, w_hs_c, commit_c, mem_we_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [STRB_W-1:0] wr_strb_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic              wr_console_c, wr_pass_c, wr_inrange_c;

  assign aw_hs_c = mem_axi_awvalid && awready_q;
  assign w_hs_c  = mem_axi_wvalid && wready_q;

  // The second capture commits directly from the live bus, so pick live or held.
  assign wr_addr_c = aw_cap_q ? awaddr_q : mem_axi_awaddr;
  assign wr_data_c = w_cap_q  ? wdata_q  : mem_axi_wdata;
  assign wr_strb_c = w_cap_q  ? wstrb_q  : mem_axi_wstrb;
  assign wr_idx_c  = wr_addr_c[SPAN_W-1:OFF_W];

  assign wr_console_c = (wr_addr_c == ADDR_W'(CONSOLE_ADDR));
  assign wr_pass_c    = (wr_addr_c == ADDR_W'(PASS_ADDR));
  assign wr_inrange_c = ((wr_addr_c >> SPAN_W) == '0);

  assign commit_c = (wstate_q == W_IDLE) && (aw_cap_q || aw_hs_c) && (w_cap_q || w_hs_c);

  always_comb begin
    wstate_d        = wstate_q;
    aw_cap_d        = aw_cap_q;
    w_cap_d         = w_cap_q;
    awaddr_d        = awaddr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    bvalid_d        = bvalid_q;
    bresp_d         = bresp_q;
    console_valid_d = 1'b0;
    console_data_d  = console_data_q;
    passed_d        = passed_q;
    mem_we_c        = 1'b0;

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          aw_cap_d = 1'b1;
          awaddr_d = mem_axi_awaddr;
        end
        if (w_hs_c) begin
          w_cap_d = 1'b1;
          wdata_d = mem_axi_wdata;
          wstrb_d = mem_axi_wstrb;
        end
        if (commit_c) begin
          wstate_d = W_RESP;
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = (wr_console_c || wr_pass_c || wr_inrange_c) ? OKAY : SLVERR;
          if (wr_console_c) begin
            console_valid_d = 1'b1;
            console_data_d  = wr_data_c[7:0];
          end
          if (wr_pass_c && (&wr_strb_c) && (wr_data_c[31:0] == PASS_VALUE)) begin
            passed_d = 1'b1;
          end
          mem_we_c = !wr_console_c && !wr_pass_c && wr_inrange_c;
        end
      end
      W_RESP: begin
        if (mem_axi_bready) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    awready_d = (wstate_d == W_IDLE) && !aw_cap_d && ready_gate[0];
    wready_d  = (wstate_d == W_IDLE) && !w_cap_d && ready_gate[1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate_q        <= W_IDLE;
      aw_cap_q        <= 1'b0;
      w_cap_q         <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      bvalid_q        <= 1'b0;
      bresp_q         <= OKAY;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      passed_q        <= 1'b0;
    end else begin
      wstate_q        <= wstate_d;
      aw_cap_q        <= aw_cap_d;
      w_cap_q         <= w_cap_d;
      awaddr_q        <= awaddr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      awready_q       <= awready_d;
      wready_q        <= wready_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      console_valid_q <= console_valid_d;
      console_data_q  <= console_data_d;
      passed_q        <= passed_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb_c[b]) begin
          mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_e           rstate_q, rstate_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_e             rresp_q, rresp_d;

  logic              ar_hs_c, rd_special_c, rd_inrange_c;
  logic [IDX_W-1:0]  rd_idx_c;

  assign ar_hs_c      = mem_axi_arvalid && arready_q;
  assign rd_idx_c     = mem_axi_araddr[SPAN_W-1:OFF_W];
  assign rd_special_c = (mem_axi_araddr == ADDR_W'(CONSOLE_ADDR)) ||
                        (mem_axi_araddr == ADDR_W'(PASS_ADDR));
  assign rd_inrange_c = ((mem_axi_araddr >> SPAN_W) == '0);

  // Memory is sampled before this edge's write lands, giving pre-write data on collision.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          if (rd_special_c) begin
            rdata_d = '0;
            rresp_d = OKAY;
          end else if (rd_inrange_c) begin
            rdata_d = mem_q[rd_idx_c];
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
        end
      end
      R_DATA: begin
        if (mem_axi_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    arready_d = (rstate_d == R_IDLE) && ready_gate[2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  logic unused_prot;
  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

  assign mem_axi_awready = awready_q;
  assign mem_axi_wready  = wready_q;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_bresp   = bresp_q;
  assign mem_axi_arready = arready_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;
  assign mem_axi_rresp   = rresp_q;
  assign console_valid   = console_valid_q;
  assign console_data    = console_data_q;
  assign tests_passed    = passed_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed and scoreboarded checks for axi_mem_slave; one unthrottled and one
// throttled instance share the stimulus, selected by sel.
module tb_axi_mem_slave;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;

  logic        awready0, wready0, bvalid0, arready0, rvalid0, cv0, tp0;
  logic        awready1, wready1, bvalid1, arready1, rvalid1, cv1, tp1;
  logic [1:0]  bresp0, rresp0, bresp1, rresp1;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  cd0, cd1;

  logic        awready, wready, bvalid, arready, rvalid, console_valid, tests_passed;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  console_data;

  assign awready       = sel ? awready1 : awready0;
  assign wready        = sel ? wready1  : wready0;
  assign bvalid        = sel ? bvalid1  : bvalid0;
  assign bresp         = sel ? bresp1   : bresp0;
  assign arready       = sel ? arready1 : arready0;
  assign rvalid        = sel ? rvalid1  : rvalid0;
  assign rdata         = sel ? rdata1   : rdata0;
  assign rresp         = sel ? rresp1   : rresp0;
  assign console_valid = sel ? cv1      : cv0;
  assign console_data  = sel ? cd1      : cd0;
  assign tests_passed  = sel ? tp1      : tp0;

  axi_mem_slave #(.AXI_TEST(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid & ~sel), .mem_axi_awready(awready0),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid & ~sel), .mem_axi_wready(wready0),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid0), .mem_axi_bready(bready & ~sel), .mem_axi_bresp(bresp0),
    .mem_axi_arvalid(arvalid & ~sel), .mem_axi_arready(arready0),
    .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid0), .mem_axi_rready(rready & ~sel),
    .mem_axi_rdata(rdata0), .mem_axi_rresp(rresp0),
    .console_valid(cv0), .console_data(cd0), .tests_passed(tp0)
  );

  axi_mem_slave #(.AXI_TEST(1'b1)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid & sel), .mem_axi_awready(awready1),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid & sel), .mem_axi_wready(wready1),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid1), .mem_axi_bready(bready & sel), .mem_axi_bresp(bresp1),
    .mem_axi_arvalid(arvalid & sel), .mem_axi_arready(arready1),
    .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid1), .mem_axi_rready(rready & sel),
    .mem_axi_rdata(rdata1), .mem_axi_rresp(rresp1),
    .console_valid(cv1), .console_data(cd1), .tests_passed(tp1)
  );

  int errors = 0;
  int checks = 0;
  logic       cv_seen;
  logic [7:0] cd_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int stall, output logic [1:0] resp,
                        output logic lat_ok, output logic stable);
    bit awd, wd;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    awd = 1'b0; wd = 1'b0; n = 0;
    while (!(awd && wd) && n < 64) begin
      @(negedge clk);
      if (awvalid && awready) awd = 1'b1;
      if (wvalid && wready) wd = 1'b1;
      @(posedge clk); #1;
      if (awd) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat_ok = bvalid;
    cv_seen = console_valid;
    cd_seen = console_data;
    n = 0;
    while (!bvalid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    resp = bresp;
    stable = bvalid;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!bvalid || bresp !== resp) stable = 1'b0;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] a, input int stall, output logic [31:0] data,
                        output logic [1:0] resp, output logic lat_ok, output logic stable);
    bit hs;
    int n;
    araddr = a; arvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 64) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    lat_ok = rvalid;
    n = 0;
    while (!rvalid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    data = rdata;
    resp = rresp;
    stable = rvalid;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  localparam int unsigned NVEC = 17;
  localparam logic [31:0] CONS = 32'h1000_0000;
  localparam logic [31:0] PASS = 32'h2000_0000;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt [NVEC];
    logic [1:0]  resp;
    logic [31:0] data;
    logic        lat, stab;
    logic [31:0] model [64];
    int unsigned w;
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          oor;
    int          stall;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1'b1, 32'h0000_0013, 32'hA5A5A5A5, 4'h0, 32'h0,        2'b00};
    vt[3]  = '{1'b0, 32'h0000_0012, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vt[4]  = '{1'b1, 32'h0000_0FFC, 32'h01234567, 4'hF, 32'h0,        2'b00};
    vt[5]  = '{1'b0, 32'h0000_0FFF, 32'h0,        4'h0, 32'h01234567, 2'b00};
    vt[6]  = '{1'b1, 32'h0000_0000, 32'h0BADC0DE, 4'hF, 32'h0,        2'b00};
    vt[7]  = '{1'b1, 32'h0000_1000, 32'hCAFEF00D, 4'hF, 32'h0,        2'b10};
    vt[8]  = '{1'b0, 32'h0000_1000, 32'h0,        4'h0, 32'h0,        2'b10};
    vt[9]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h0BADC0DE, 2'b00};
    vt[10] = '{1'b1, 32'h0001_0000, 32'h00000055, 4'hF, 32'h0,        2'b10};
    vt[11] = '{1'b0, 32'h0001_0000, 32'h0,        4'h0, 32'h0,        2'b10};
    vt[12] = '{1'b0, CONS,          32'h0,        4'h0, 32'h0,        2'b00};
    vt[13] = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vt[14] = '{1'b1, 32'h0000_0020, 32'h00000000, 4'h5, 32'h0,        2'b00};
    vt[15] = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
    vt[16] = '{1'b0, PASS,          32'h0,        4'h0, 32'h0,        2'b00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst awready", 32'(awready), 32'd0);
    chk("rst wready", 32'(wready), 32'd0);
    chk("rst arready", 32'(arready), 32'd0);
    chk("rst bvalid", 32'(bvalid), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst console_valid", 32'(console_valid), 32'd0);
    chk("rst tests_passed", 32'(tests_passed), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post-rst awready", 32'(awready), 32'd1);
    chk("post-rst wready", 32'(wready), 32'd1);
    chk("post-rst arready", 32'(arready), 32'd1);

    // Table-driven single transactions
    for (int i = 0; i < int'(NVEC); i++) begin
      if (vt[i].wr) begin
        axi_wr(vt[i].addr, vt[i].data, vt[i].strb, 0, resp, lat, stab);
        chk($sformatf("vec%0d bvalid latency", i), 32'(lat), 32'd1);
        chk($sformatf("vec%0d bresp", i), 32'(resp), 32'(vt[i].resp));
      end else begin
        axi_rd(vt[i].addr, 0, data, resp, lat, stab);
        chk($sformatf("vec%0d rvalid latency", i), 32'(lat), 32'd1);
        chk($sformatf("vec%0d rdata", i), data, vt[i].exp);
        chk($sformatf("vec%0d rresp", i), 32'(resp), 32'(vt[i].resp));
      end
    end
    chk("normal write no console", 32'(cv_seen), 32'd0);

    // Split channels: W two cycles ahead of AW, byte strobe 0x2
    wdata = 32'h11223344; wstrb = 4'h2; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("split wready drops", 32'(wready), 32'd0);
    chk("split awready held", 32'(awready), 32'd1);
    chk("split no early bvalid", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    chk("split no bvalid 2", 32'(bvalid), 32'd0);
    awaddr = 32'h10; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("split bvalid after aw", 32'(bvalid), 32'd1);
    chk("split bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("split bvalid cleared", 32'(bvalid), 32'd0);
    chk("split awready returns", 32'(awready), 32'd1);
    chk("split wready returns", 32'(wready), 32'd1);
    axi_rd(32'h10, 0, data, resp, lat, stab);
    chk("split readback", data, 32'hDEAD33EF);
    chk("arready returns after R", 32'(arready), 32'd1);

    // Same-cycle AR and write commit to one word returns pre-write data
    awaddr = 32'h10; wdata = 32'h5555AAAA; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("collide bvalid", 32'(bvalid), 32'd1);
    chk("collide rvalid", 32'(rvalid), 32'd1);
    chk("collide rdata old", rdata, 32'hDEAD33EF);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_rd(32'h10, 0, data, resp, lat, stab);
    chk("collide new data", data, 32'h5555AAAA);

    // Console pulse
    axi_wr(CONS, 32'h00000041, 4'hF, 0, resp, lat, stab);
    chk("console valid at commit", 32'(cv_seen), 32'd1);
    chk("console data", 32'(cd_seen), 32'h41);
    chk("console bresp", 32'(resp), 32'd0);
    chk("console pulse ends", 32'(console_valid), 32'd0);

    // Pass flag qualification
    axi_wr(PASS, 32'd123456789, 4'h7, 0, resp, lat, stab);
    chk("pass partial strb", 32'(tests_passed), 32'd0);
    axi_wr(PASS, 32'd123456788, 4'hF, 0, resp, lat, stab);
    chk("pass wrong value", 32'(tests_passed), 32'd0);
    axi_wr(PASS, 32'd123456789, 4'hF, 0, resp, lat, stab);
    chk("pass set", 32'(tests_passed), 32'd1);
    chk("pass bresp", 32'(resp), 32'd0);
    axi_wr(PASS, 32'd0, 4'h7, 0, resp, lat, stab);
    chk("pass sticky", 32'(tests_passed), 32'd1);

    // Reset while a write response is stalled
    awaddr = 32'h30; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("midrst bvalid pending", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst bvalid cleared", 32'(bvalid), 32'd0);
    chk("midrst awready low", 32'(awready), 32'd0);
    chk("midrst pass cleared", 32'(tests_passed), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst awready after release", 32'(awready), 32'd1);
    chk("midrst no stale bvalid", 32'(bvalid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst still no bvalid", 32'(bvalid), 32'd0);

    // Throttled instance: preload a window, then random traffic against a model
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      model[i] = d;
      axi_wr(32'(i * 4), d, 4'hF, 0, resp, lat, stab);
      chk($sformatf("preload %0d bresp", i), 32'(resp), 32'd0);
    end
    for (int k = 0; k < 1000; k++) begin
      w = $urandom_range(0, 63);
      oor = ($urandom_range(0, 15) == 0);
      a = oor ? 32'(32'h0000_4000 + w * 4) : 32'(w * 4);
      stall = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_wr(a, d, s, stall, resp, lat, stab);
        if (!oor) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
          end
        end
        chk($sformatf("stress%0d bresp", k), 32'(resp), oor ? 32'd2 : 32'd0);
        chk($sformatf("stress%0d b timing/stable", k), 32'({lat, stab}), 32'd3);
      end else begin
        axi_rd(a, stall, data, resp, lat, stab);
        chk($sformatf("stress%0d rdata", k), data, oor ? 32'd0 : model[w]);
        chk($sformatf("stress%0d rresp", k), 32'(resp), oor ? 32'd2 : 32'd0);
        chk($sformatf("stress%0d r timing/stable", k), 32'({lat, stab}), 32'd3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
